// File: rtl/fifo_rd_stream_if.sv
// fifo_rd_stream_if: bundles the FIFO read port and the outgoing valid/ready
// stream of the read-side drain engine.
//   master : the drain engine (issues FIFO reads, drives the stream)
//   slave  : the environment (FIFO read side plus stream sink)
interface fifo_rd_stream_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_rd_data;
    logic                  fifo_rd_en;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;

    modport master (
        input  fifo_empty,
        input  fifo_rd_data,
        output fifo_rd_en,
        output m_valid,
        input  m_ready,
        output m_data
    );

    modport slave (
        output fifo_empty,
        output fifo_rd_data,
        input  fifo_rd_en,
        input  m_valid,
        output m_ready,
        input  m_data
    );
endinterface

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: read-side drain engine for the dual-clock FIFO.
// Issues FIFO reads (1-cycle registered read latency) into a small circular
// prefetch buffer and presents the words as a full-throughput valid/ready
// stream. The read request depends only on registered state and fifo_empty,
// so the sink's m_ready never reaches fifo_rd_en combinationally.
// Optional: define FIFO_RD_STREAM_STATS_EN to add a saturating 32-bit
// delivered-word counter on output port word_cnt.
module fifo_rd_stream #(
    parameter int DATA_WIDTH = 8,
    parameter int BUF_DEPTH  = 3
) (
    input  logic             rd_clk,
    input  logic             rd_rst_n,
    fifo_rd_stream_if.master bus
`ifdef FIFO_RD_STREAM_STATS_EN
    ,
    output logic [31:0]      word_cnt
`endif
);

    localparam int OCC_W = $clog2(BUF_DEPTH + 1);
    localparam int IDX_W = $clog2(BUF_DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BUF_DEPTH - 1);
    localparam logic [OCC_W:0]   DEPTH_W  = (OCC_W + 1)'(BUF_DEPTH);

    logic [OCC_W-1:0]      occ_q, occ_d;
    logic                  inflight_q;
    logic [IDX_W-1:0]      wr_idx_q, wr_idx_d;
    logic [IDX_W-1:0]      rd_idx_q, rd_idx_d;
    logic [DATA_WIDTH-1:0] buf_q [BUF_DEPTH];
    logic [OCC_W:0]        committed;
    logic                  rd_en;
    logic                  valid;
    logic                  pop;

    // Circular index increment; depth need not be a power of two.
    function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] idx);
        return (idx == LAST_IDX) ? '0 : idx + 1'b1;
    endfunction

    // Entries already buffered plus the one still returning from the FIFO.
    assign committed = {1'b0, occ_q} + {{OCC_W{1'b0}}, inflight_q};

    // Only request a word when a buffer slot is guaranteed for its return.
    assign rd_en = rd_rst_n && !bus.fifo_empty && (committed < DEPTH_W);
    assign valid = (occ_q != '0);
    assign pop   = valid && bus.m_ready;

    assign bus.fifo_rd_en = rd_en;
    assign bus.m_valid    = valid;
    assign bus.m_data     = buf_q[rd_idx_q];

    // Next-state for occupancy and the two circular indices.
    always_comb begin
        occ_d    = occ_q + {{(OCC_W-1){1'b0}}, inflight_q} - {{(OCC_W-1){1'b0}}, pop};
        wr_idx_d = wr_idx_q;
        rd_idx_d = rd_idx_q;
        if (inflight_q) begin
            wr_idx_d = idx_inc(wr_idx_q);
        end
        if (pop) begin
            rd_idx_d = idx_inc(rd_idx_q);
        end
    end

    // Control state: occupancy, in-flight flag and buffer indices.
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            occ_q      <= '0;
            inflight_q <= 1'b0;
            wr_idx_q   <= '0;
            rd_idx_q   <= '0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= rd_en;
            wr_idx_q   <= wr_idx_d;
            rd_idx_q   <= rd_idx_d;
        end
    end

    // Prefetch buffer: capture the returning FIFO word in the slot at wr_idx.
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_q[i] <= '0;
            end
        end else if (inflight_q) begin
            buf_q[wr_idx_q] <= bus.fifo_rd_data;
        end
    end

`ifdef FIFO_RD_STREAM_STATS_EN
    logic [31:0] word_cnt_q;

    // Delivered-word counter, saturating at all-ones.
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            word_cnt_q <= '0;
        end else if (pop && (word_cnt_q != 32'hFFFF_FFFF)) begin
            word_cnt_q <= word_cnt_q + 32'd1;
        end
    end

    assign word_cnt = word_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: self-checking bench for fifo_rd_stream.
// A behavioural FIFO (array + read/write pointers) feeds the engine; every
// accepted stream word is logged and compared against the order in which
// words were written into the FIFO. Stall stability and the buffer bound
// (reads issued minus words delivered) are checked per cycle.
module tb_fifo_rd_stream;

    localparam int DW = 8;
    localparam int BD = 3;

    logic rd_clk = 1'b0;
    logic rd_rst_n = 1'b0;
    always #5 rd_clk = ~rd_clk;

    fifo_rd_stream_if #(.DATA_WIDTH(DW)) bus();

`ifdef FIFO_RD_STREAM_STATS_EN
    logic [31:0] word_cnt;
`endif

    fifo_rd_stream #(.DATA_WIDTH(DW), .BUF_DEPTH(BD)) dut (
        .rd_clk   (rd_clk),
        .rd_rst_n (rd_rst_n),
        .bus      (bus)
`ifdef FIFO_RD_STREAM_STATS_EN
        ,
        .word_cnt (word_cnt)
`endif
    );

    // ---------------- behavioural FIFO ----------------
    logic [DW-1:0] fmem [1024];
    int            wr_ptr = 0;
    int            rd_ptr = 0;
    logic          hold_empty = 1'b0;
    logic [DW-1:0] rd_data_r = '0;

    assign bus.fifo_empty   = hold_empty || (wr_ptr == rd_ptr);
    assign bus.fifo_rd_data = rd_data_r;

    // Registered read; junk on the data bus when no read was accepted.
    always @(posedge rd_clk) begin
        if (bus.fifo_rd_en) begin
            rd_data_r <= fmem[rd_ptr % 1024];
            rd_ptr    <= rd_ptr + 1;
        end else begin
            rd_data_r <= DW'($urandom);
        end
    end

    // ---------------- bench state ----------------
    int            total = 0;
    int            bad = 0;
    logic [DW-1:0] got[$];
    int            issued = 0;
    int            pend_max = 0;
    logic          obs_en, obs_valid, obs_ready;
    logic [DW-1:0] obs_data;

    task automatic push(input logic [DW-1:0] w);
        fmem[wr_ptr % 1024] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    // Observe one cycle (inputs already applied at this negedge), then advance.
    task automatic cyc();
        int pend;
        #1;
        obs_en    = bus.fifo_rd_en;
        obs_valid = bus.m_valid;
        obs_ready = bus.m_ready;
        obs_data  = bus.m_data;
        pend = issued - got.size();
        if (pend > pend_max) pend_max = pend;
        if (obs_en) issued++;
        if (obs_valid && obs_ready) got.push_back(obs_data);
        @(negedge rd_clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int base;
        bus.m_ready = 1'b1;
        push(8'hC0);
        push(8'hC1);
        for (int c = 0; c < 4; c++) begin
            cyc();
            total++;
            if (obs_en !== 1'b0) begin bad++; $display("FAIL reset_rd_en c=%0d got=%b want=0", c, obs_en); end
            total++;
            if (obs_valid !== 1'b0) begin bad++; $display("FAIL reset_valid c=%0d got=%b want=0", c, obs_valid); end
            total++;
            if (obs_data !== 8'h00) begin bad++; $display("FAIL reset_data c=%0d got=%h want=00", c, obs_data); end
        end
        base = got.size();
        rd_rst_n = 1'b1;
        for (int k = 0; k < 20 && got.size() < base + 2; k++) cyc();
        total++;
        if (got.size() != base + 2) begin
            bad++; $display("FAIL reset_release_count got=%0d want=2", got.size() - base);
        end else begin
            total++;
            if (got[base] !== 8'hC0 || got[base+1] !== 8'hC1) begin
                bad++; $display("FAIL reset_release_data got=%h,%h want=c0,c1", got[base], got[base+1]);
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_latency();
        logic          e_en [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic          e_v  [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [DW-1:0] e_d  [6] = '{8'h00, 8'h00, 8'hA1, 8'hA2, 8'hA3, 8'h00};
        bus.m_ready = 1'b1;
        push(8'hA1);
        push(8'hA2);
        push(8'hA3);
        for (int c = 0; c < 6; c++) begin
            cyc();
            total++;
            if (obs_en !== e_en[c]) begin bad++; $display("FAIL latency_rd_en c=%0d got=%b want=%b", c, obs_en, e_en[c]); end
            total++;
            if (obs_valid !== e_v[c]) begin bad++; $display("FAIL latency_valid c=%0d got=%b want=%b", c, obs_valid, e_v[c]); end
            if (e_v[c]) begin
                total++;
                if (obs_data !== e_d[c]) begin bad++; $display("FAIL latency_data c=%0d got=%h want=%h", c, obs_data, e_d[c]); end
            end
        end
        $display("test_latency done");
    endtask

    task automatic test_stall();
        int base_iss, base;
        bus.m_ready = 1'b0;
        base_iss = issued;
        base = got.size();
        for (int i = 0; i < 5; i++) push(8'(8'h10 + i));
        for (int c = 0; c < 6; c++) begin
            cyc();
            if (c >= 3) begin
                total++;
                if (obs_en !== 1'b0) begin bad++; $display("FAIL stall_rd_en c=%0d got=%b want=0", c, obs_en); end
                total++;
                if (obs_valid !== 1'b1 || obs_data !== 8'h10) begin
                    bad++; $display("FAIL stall_hold c=%0d got=%b/%h want=1/10", c, obs_valid, obs_data);
                end
            end
        end
        total++;
        if (issued - base_iss != 3) begin bad++; $display("FAIL stall_reads got=%0d want=3", issued - base_iss); end
        bus.m_ready = 1'b1;
        for (int k = 0; k < 30 && got.size() < base + 5; k++) cyc();
        total++;
        if (got.size() != base + 5) begin
            bad++; $display("FAIL stall_count got=%0d want=5", got.size() - base);
        end else begin
            for (int i = 0; i < 5; i++) begin
                total++;
                if (got[base+i] !== 8'(8'h10 + i)) begin
                    bad++; $display("FAIL stall_order i=%0d got=%h want=%h", i, got[base+i], 8'(8'h10 + i));
                end
            end
        end
        $display("test_stall done");
    endtask

    task automatic test_toggle();
        int base;
        base = got.size();
        pend_max = 0;
        for (int i = 0; i < 8; i++) push(8'(i));
        for (int k = 0; k < 60 && got.size() < base + 8; k++) begin
            bus.m_ready = (k % 2 == 0);
            cyc();
        end
        total++;
        if (got.size() != base + 8) begin
            bad++; $display("FAIL toggle_count got=%0d want=8", got.size() - base);
        end else begin
            for (int i = 0; i < 8; i++) begin
                total++;
                if (got[base+i] !== 8'(i)) begin bad++; $display("FAIL toggle_order i=%0d got=%h want=%h", i, got[base+i], 8'(i)); end
            end
        end
        total++;
        if (pend_max > BD) begin bad++; $display("FAIL toggle_occ got=%0d want<=%0d", pend_max, BD); end
        bus.m_ready = 1'b1;
        cyc();
        $display("test_toggle done");
    endtask

    task automatic test_back_to_back();
        int base, first, last;
        base = got.size();
        first = -1;
        last = -1;
        bus.m_ready = 1'b1;
        for (int i = 0; i < 12; i++) push(8'(8'h30 + i));
        for (int k = 0; k < 40 && got.size() < base + 12; k++) begin
            cyc();
            if (obs_valid && obs_ready) begin
                if (first < 0) first = k;
                last = k;
            end
        end
        total++;
        if (got.size() != base + 12 || last - first != 11) begin
            bad++; $display("FAIL b2b_throughput words=%0d span=%0d want=12/11", got.size() - base, last - first);
        end
        total++;
        if (first != 2) begin bad++; $display("FAIL b2b_first got=%0d want=2", first); end
        for (int i = 0; i < 12 && base + i < got.size(); i++) begin
            total++;
            if (got[base+i] !== 8'(8'h30 + i)) begin bad++; $display("FAIL b2b_order i=%0d got=%h want=%h", i, got[base+i], 8'(8'h30 + i)); end
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_reset_mid();
        int base;
        bus.m_ready = 1'b0;
        for (int i = 0; i < 8; i++) push(8'(8'h50 + i));
        for (int c = 0; c < 3; c++) cyc();
        total++;
        if (issued - got.size() != 3) begin bad++; $display("FAIL mid_pending got=%0d want=3", issued - got.size()); end
        rd_rst_n = 1'b0;
        #1;
        total++;
        if (bus.m_valid !== 1'b0 || bus.m_data !== 8'h00 || bus.fifo_rd_en !== 1'b0) begin
            bad++; $display("FAIL mid_reset_now got=%b/%h/%b want=0/00/0", bus.m_valid, bus.m_data, bus.fifo_rd_en);
        end
        issued = got.size();
        @(negedge rd_clk);
        rd_rst_n = 1'b1;
        bus.m_ready = 1'b1;
        base = got.size();
        cyc();
        total++;
        if (obs_valid !== 1'b0) begin bad++; $display("FAIL mid_after_release got=%b want=0", obs_valid); end
        for (int k = 0; k < 30 && got.size() < base + 5; k++) cyc();
        total++;
        if (got.size() != base + 5) begin
            bad++; $display("FAIL mid_count got=%0d want=5", got.size() - base);
        end else begin
            for (int i = 0; i < 5; i++) begin
                total++;
                if (got[base+i] !== 8'(8'h53 + i)) begin bad++; $display("FAIL mid_order i=%0d got=%h want=%h", i, got[base+i], 8'(8'h53 + i)); end
            end
        end
        $display("test_reset_mid done");
    endtask

    task automatic test_random();
        logic [DW-1:0] ex[$];
        int            base;
        logic          pv, pr;
        logic [DW-1:0] pd;
        base = got.size();
        pend_max = 0;
        pv = 1'b0;
        pr = 1'b0;
        pd = '0;
        for (int k = 0; k < 400; k++) begin
            for (int j = $urandom_range(0, 2); j > 0; j--) begin
                if (wr_ptr - rd_ptr < 500) begin
                    logic [DW-1:0] w;
                    w = DW'($urandom);
                    push(w);
                    ex.push_back(w);
                end
            end
            hold_empty  = ($urandom_range(0, 7) == 0);
            bus.m_ready = ($urandom_range(0, 2) != 0);
            cyc();
            if (pv && !pr) begin
                total++;
                if (obs_valid !== 1'b1 || obs_data !== pd) begin
                    bad++; $display("FAIL rand_stall k=%0d got=%b/%h want=1/%h", k, obs_valid, obs_data, pd);
                end
            end
            pv = obs_valid;
            pr = obs_ready;
            pd = obs_data;
        end
        hold_empty = 1'b0;
        bus.m_ready = 1'b1;
        for (int k = 0; k < 2000 && got.size() < base + ex.size(); k++) cyc();
        total++;
        if (got.size() != base + ex.size()) begin
            bad++; $display("FAIL rand_count got=%0d want=%0d", got.size() - base, ex.size());
        end
        for (int i = 0; i < ex.size() && base + i < got.size(); i++) begin
            if (got[base+i] !== ex[i]) begin
                total++;
                bad++; $display("FAIL rand_order i=%0d got=%h want=%h", i, got[base+i], ex[i]);
            end
        end
        total++;
        if (pend_max > BD) begin bad++; $display("FAIL rand_occ got=%0d want<=%0d", pend_max, BD); end
        $display("test_random done words=%0d", ex.size());
    endtask

`ifdef FIFO_RD_STREAM_STATS_EN
    task automatic test_stats();
        int base;
        rd_rst_n = 1'b0;
        issued = got.size();
        #1;
        total++;
        if (word_cnt !== 32'd0) begin bad++; $display("FAIL stats_reset got=%h want=0", word_cnt); end
        @(negedge rd_clk);
        rd_rst_n = 1'b1;
        bus.m_ready = 1'b1;
        base = got.size();
        for (int i = 0; i < 20; i++) push(8'(8'h80 + i));
        for (int k = 0; k < 60 && got.size() < base + 20; k++) cyc();
        total++;
        if (word_cnt !== 32'd20) begin bad++; $display("FAIL stats_count got=%0d want=20", word_cnt); end
        force dut.word_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.word_cnt_q;
        base = got.size();
        for (int i = 0; i < 3; i++) push(8'(8'hE0 + i));
        for (int k = 0; k < 20 && got.size() < base + 3; k++) cyc();
        total++;
        if (word_cnt !== 32'hFFFF_FFFF) begin bad++; $display("FAIL stats_saturate got=%h want=ffffffff", word_cnt); end
        $display("test_stats done");
    endtask
`endif

    initial begin
        bus.m_ready = 1'b0;
        rd_rst_n = 1'b0;
        @(negedge rd_clk);
        test_reset();
        test_latency();
        test_stall();
        test_toggle();
        test_back_to_back();
        test_reset_mid();
        test_random();
`ifdef FIFO_RD_STREAM_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
